// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared constants for the ADC line capture sequencer
//
// Purpose: sequencer state encoding, default widths and the ADC watchdog limit.
// Used by adc_line_capture and adc_sample_fifo via import adc_capture_pkg::*.
package adc_capture_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int FIFO_AW_DEF = 4;

  // Sequencer states (3-bit, fixed encoding so existing debug taps stay valid)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_ACK  = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Cycles spent in REQ without a completion before the request is abandoned
  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

endpackage

// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - synchronous show-ahead sample FIFO
//
// Purpose: buffers ADC samples between the capture sequencer and the APB side.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   wrEn, wrData    push request and sample
//   rdEn            pop head (ignored when empty)
//   rdData          current head, valid whenever empty=0
//   empty, full     occupancy flags, derived from count
//   count           occupancy 0..2^AW
//   wrDrop          push rejected this cycle (full and no simultaneous pop)
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = FIFO_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              wrDrop
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic              wrOk;
  logic              rdOk;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  // A push into a full FIFO still lands when the head is popped in the same
  // cycle: the freed slot is exactly the one being written.
  assign wrOk   = wrEn && (!full || rdEn);
  assign rdOk   = rdEn && !empty;
  assign wrDrop = wrEn && full && !rdEn;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrOk) wrPtr <= wrPtr + AW'(1);
      if (rdOk) rdPtr <= rdPtr + AW'(1);
      case ({wrOk, rdOk})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrOk) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/adc_line_capture.sv
// rtl/adc_line_capture.sv - ADC081S101 line capture sequencer with sample FIFO
//
// Purpose: requests LINE_LEN conversions from the serial ADC driver per
// start_line trigger and buffers the samples for the APB-side reader.
// Optional macro ADC_TIMEOUT_EN adds a 16-bit REQ watchdog and the timeout flag.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   enable, start_line    capture enable (abort when low), line trigger pulse
//   adc_start_n           capture request to driver (active low)
//   adc_done_n, adc_data  completion strobe (active low) and sample from driver
//   rd_en, rd_data        FIFO pop and show-ahead head
//   fifo_empty/full/count FIFO status
//   line_busy, line_done  not idle, end-of-line pulse
//   overflow, clear_ovf   sticky dropped-sample flag and its clear
//   timeout               sticky ADC watchdog flag
module adc_line_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LINE_LEN = 112,
  parameter int CNT_W    = 8,
  parameter int FIFO_AW  = FIFO_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start_line,
  output logic               adc_start_n,
  input  logic               adc_done_n,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               line_busy,
  output logic               line_done,
  output logic               overflow,
  input  logic               clear_ovf,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(LINE_LEN - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] pixCnt;
  logic             push;
  logic             wrDrop;

  // The sample is taken straight off the driver bus in the completion cycle,
  // so the FIFO write itself is the data latch.
  assign push        = (state == ST_REQ) && !adc_done_n;
  assign adc_start_n = (state != ST_REQ);
  assign line_busy   = (state != ST_IDLE);
  assign line_done   = (state == ST_DONE);

`ifdef ADC_TIMEOUT_EN
  logic [15:0] wdog;
  logic        wdogHit;
  logic        timeoutFlag;

  assign wdogHit = (state == ST_REQ) && adc_done_n && (wdog == WDOG_LIMIT);
  assign timeout = timeoutFlag;

  // Held at zero outside REQ, so every entry into REQ starts a fresh count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog        <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      if (state != ST_REQ)
        wdog <= '0;
      else if (adc_done_n && wdog != WDOG_LIMIT)
        wdog <= wdog + 16'd1;
      if (wdogHit) timeoutFlag <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      pixCnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_line && enable) begin
            state  <= ST_REQ;
            pixCnt <= '0;
          end
        end
        // The driver cannot be cancelled mid-conversion, so enable is only
        // honoured once the handshake has fully closed (in NEXT).
        ST_REQ: begin
          if (!adc_done_n)
            state <= ST_ACK;
`ifdef ADC_TIMEOUT_EN
          else if (wdogHit)
            state <= ST_IDLE;
`endif
        end
        ST_ACK: begin
          if (adc_done_n) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (!enable)
            state <= ST_IDLE;
          else if (pixCnt == LAST_PIX)
            state <= ST_DONE;
          else begin
            pixCnt <= pixCnt + CNT_W'(1);
            state  <= ST_REQ;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // clear_ovf has priority so software never loses a clear to a racing drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else if (clear_ovf)
      overflow <= 1'b0;
    else if (wrDrop)
      overflow <= 1'b1;
  end

  adc_sample_fifo #(
    .DATA_W (DATA_W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (push),
    .wrData (adc_data),
    .rdEn   (rd_en),
    .rdData (rd_data),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count),
    .wrDrop (wrDrop)
  );

endmodule

// File: tb/tb_adc_line_capture.sv
// tb/tb_adc_line_capture.sv - directed self-checking bench for adc_line_capture
module tb_adc_line_capture;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       start_line;
  logic       adc_start_n;
  logic       adcDoneN;
  logic [7:0] adcData;
  logic       rdMain;
  logic       rdModel;
  logic       rdEn;
  logic [7:0] rd_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       line_busy;
  logic       line_done;
  logic       overflow;
  logic       clear_ovf;
  logic       timeout;

  int checks = 0;
  int failures = 0;
  int lineDoneCnt = 0;
  int sampleIdx = 0;
  int respDelay = 3;
  int holdCycles = 1;
  bit modelEn = 1;
  bit popOnPush = 0;

  assign rdEn = rdMain | rdModel;

  adc_line_capture #(
    .DATA_W   (8),
    .LINE_LEN (4),
    .CNT_W    (8),
    .FIFO_AW  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start_line  (start_line),
    .adc_start_n (adc_start_n),
    .adc_done_n  (adcDoneN),
    .adc_data    (adcData),
    .rd_en       (rdEn),
    .rd_data     (rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .line_busy   (line_busy),
    .line_done   (line_done),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf),
    .timeout     (timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] sval(input int i);
    return 8'((i + 1) * 17);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart();
    start_line = 1;
    @(negedge clk);
    start_line = 0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (line_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, line_busy}, 32'd0);
  endtask

  task automatic popCheck(input logic [7:0] exp, input string tag);
    chk(tag, {24'b0, rd_data}, {24'b0, exp});
    rdMain = 1;
    @(negedge clk);
    rdMain = 0;
  endtask

  always @(negedge clk) if (line_done === 1'b1) lineDoneCnt++;

  // ADC driver model: answers a request after respDelay cycles and holds the
  // completion strobe for holdCycles cycles, checking the request stays off.
  initial begin
    adcDoneN = 1;
    adcData = 0;
    rdModel = 0;
    forever begin
      @(negedge clk);
      if (modelEn && adc_start_n === 1'b0) begin
        repeat (respDelay) @(negedge clk);
        adcData = sval(sampleIdx);
        sampleIdx++;
        adcDoneN = 0;
        rdModel = popOnPush;
        for (int k = 0; k < holdCycles; k++) begin
          @(negedge clk);
          rdModel = 0;
          chk("hs_start_high", {31'b0, adc_start_n}, 32'd1);
        end
        adcDoneN = 1;
      end
    end
  end

  initial begin
    int ldBase;
    int n;
    reset = 0;
    enable = 0;
    start_line = 0;
    rdMain = 0;
    clear_ovf = 0;
    repeat (2) @(negedge clk);

    chk("rst_start_n", {31'b0, adc_start_n}, 32'd1);
    chk("rst_empty", {31'b0, fifo_empty}, 32'd1);
    chk("rst_full", {31'b0, fifo_full}, 32'd0);
    chk("rst_count", {27'b0, fifo_count}, 32'd0);
    chk("rst_busy", {31'b0, line_busy}, 32'd0);
    chk("rst_done", {31'b0, line_done}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);

    reset = 1;
    enable = 1;
    @(negedge clk);

    // Basic line
    pulseStart();
    chk("basic_busy", {31'b0, line_busy}, 32'd1);
    waitIdle(300, "basic_idle");
    chk("basic_count", {27'b0, fifo_count}, 32'd4);
    chk("basic_done_pulses", lineDoneCnt, 32'd1);
    popCheck(8'h11, "basic_d0");
    popCheck(8'h22, "basic_d1");
    popCheck(8'h33, "basic_d2");
    popCheck(8'h44, "basic_d3");
    chk("basic_empty", {31'b0, fifo_empty}, 32'd1);

    // Long completion strobe: one push per sample
    holdCycles = 5;
    pulseStart();
    waitIdle(400, "hs_idle");
    chk("hs_count", {27'b0, fifo_count}, 32'd4);
    popCheck(8'h55, "hs_d0");
    popCheck(8'h66, "hs_d1");
    popCheck(8'h77, "hs_d2");
    popCheck(8'h88, "hs_d3");
    chk("hs_empty", {31'b0, fifo_empty}, 32'd1);
    holdCycles = 1;

    // Overflow: 20 samples with no reads
    sampleIdx = 0;
    ldBase = lineDoneCnt;
    for (int l = 0; l < 4; l++) begin
      pulseStart();
      waitIdle(300, "ovf_line_idle");
    end
    chk("ovf_count16", {27'b0, fifo_count}, 32'd16);
    chk("ovf_full", {31'b0, fifo_full}, 32'd1);
    chk("ovf_not_yet", {31'b0, overflow}, 32'd0);
    pulseStart();
    waitIdle(300, "ovf_line5_idle");
    chk("ovf_set", {31'b0, overflow}, 32'd1);
    chk("ovf_count_hold", {27'b0, fifo_count}, 32'd16);
    chk("ovf_done_pulses", lineDoneCnt - ldBase, 32'd5);
    clear_ovf = 1;
    @(negedge clk);
    clear_ovf = 0;
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);

    // Push with simultaneous pop while full
    popOnPush = 1;
    pulseStart();
    waitIdle(300, "pp_idle");
    popOnPush = 0;
    chk("pp_count", {27'b0, fifo_count}, 32'd16);
    chk("pp_full", {31'b0, fifo_full}, 32'd1);
    chk("pp_no_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 4; i < 16; i++) popCheck(sval(i), "pp_drain_old");
    for (int i = 20; i < 24; i++) popCheck(sval(i), "pp_drain_new");
    chk("pp_empty", {31'b0, fifo_empty}, 32'd1);

    // Abort during the third sample
    sampleIdx = 0;
    respDelay = 6;
    ldBase = lineDoneCnt;
    pulseStart();
    n = 0;
    while (!(fifo_count === 5'd2 && adc_start_n === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_s3", {31'b0, (n < 200)}, 32'd1);
    enable = 0;
    waitIdle(300, "abort_idle");
    chk("abort_count", {27'b0, fifo_count}, 32'd3);
    chk("abort_no_done", lineDoneCnt - ldBase, 32'd0);
    popCheck(8'h11, "abort_d0");
    popCheck(8'h22, "abort_d1");
    popCheck(8'h33, "abort_d2");
    respDelay = 3;
    pulseStart();
    chk("disabled_start_ignored", {31'b0, line_busy}, 32'd0);
    enable = 1;

    // Asynchronous reset mid-line
    pulseStart();
    n = 0;
    while (!(fifo_count === 5'd1 && adc_start_n === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_req", {31'b0, (n < 200)}, 32'd1);
    #2 reset = 0;
    #1;
    chk("mid_start_n", {31'b0, adc_start_n}, 32'd1);
    chk("mid_count", {27'b0, fifo_count}, 32'd0);
    chk("mid_empty", {31'b0, fifo_empty}, 32'd1);
    chk("mid_busy", {31'b0, line_busy}, 32'd0);
    chk("mid_ovf", {31'b0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (20) @(negedge clk);

`ifdef ADC_TIMEOUT_EN
    modelEn = 0;
    ldBase = lineDoneCnt;
    pulseStart();
    waitIdle(70000, "to_idle");
    chk("to_start_n", {31'b0, adc_start_n}, 32'd1);
    chk("to_flag", {31'b0, timeout}, 32'd1);
    chk("to_count", {27'b0, fifo_count}, 32'd0);
    chk("to_no_done", lineDoneCnt - ldBase, 32'd0);
`else
    chk("timeout_tied_low", {31'b0, timeout}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
